// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path definitions: widths, PC stride, FSM encoding and queue entry layout.
package fetch_queue_pkg;

    localparam int ADDR_W  = 64;
    localparam int INST_W  = 32;
    localparam int PC_INCR = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Sequential fetch address; wraps silently at the top of the address space.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(PC_INCR);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory request channel and instruction-delivery channel of the fetch queue.
interface fetch_queue_if;
    import fetch_queue_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_data;
    logic              inst_valid;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Circular buffer of {pc, instruction} entries with push, pop, flush and occupancy count.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     resetl,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only; validity is tracked entirely by the pointers and count.
    always_ff @(posedge CLK) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: one-outstanding-request fetch FSM feeding a small in-order FIFO.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   resetl,
    input  logic [ADDR_W-1:0]      startpc,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    fetch_queue_if.master          bus,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              ack;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  post_cnt;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // An ack is only meaningful while our request is on the bus.
    assign ack      = req_q && bus.imem_ack;
    assign pop      = bus.inst_valid && bus.inst_ready && !redirect;
    assign post_cnt = count + CNT_W'(1) - CNT_W'(pop);

    assign push_entry.pc   = fetch_pc_q;
    assign push_entry.inst = bus.imem_data;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        push       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (count < DEPTH_C) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    if (ack) begin
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end else if (ack) begin
                    push       = 1'b1;
                    fetch_pc_d = pc_inc(fetch_pc_q);
                    if (post_cnt < DEPTH_C) begin
                        addr_d = pc_inc(fetch_pc_q);
                    end else begin
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                // The stale request must complete on the bus before a new one can start.
                if (redirect) fetch_pc_d = redirect_pc;
                if (ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= startpc;
            req_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .resetl      (resetl),
        .flush_i     (redirect),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count)
    );

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = (count != '0);
    assign bus.inst_data  = head.inst;
    assign bus.inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based behavioural model.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        resetl;
    logic [63:0] startpc;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [2:0]  count_w;

    fetch_queue_if fi();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .CLK         (CLK),
        .resetl      (resetl),
        .startpc     (startpc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (fi),
        .count       (count_w)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;
    logic [63:0] m_addr;
    logic        m_req;
    logic        m_stale;

    int   n_vec;
    int   n_bad;
    int   mem_lat;
    int   mem_cnt;
    bit   lat_rand;
    logic force_ack;
    int   acks;

    function automatic logic [31:0] inst_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: memory responds, model predicts the post-edge state, then the DUT is compared.
    task automatic tick();
        logic ack;
        logic hit;
        int   pre;
        if (fi.imem_req === 1'b1) begin
            ack = (mem_cnt >= mem_lat);
            fi.imem_data = inst_word(fi.imem_addr);
        end else begin
            ack = force_ack;
            fi.imem_data = 32'hDEAD_BEEF;
        end
        fi.imem_ack = ack;
        if (fi.imem_req === 1'b1 && ack) acks++;
        if (fi.imem_req === 1'b1 && !ack) mem_cnt++;
        else begin
            mem_cnt = 0;
            if (lat_rand) mem_lat = $urandom_range(0, 3);
        end

        if (!resetl) begin
            mq.delete();
            m_pc    = startpc;
            m_stale = 1'b0;
            m_req   = 1'b0;
            m_addr  = '0;
        end else begin
            hit = m_req && ack;
            pre = mq.size();
            if (redirect) begin
                mq.delete();
                m_pc = redirect_pc;
                if (hit) begin
                    m_req   = 1'b0;
                    m_stale = 1'b0;
                end else if (m_req) begin
                    m_stale = 1'b1;
                end
            end else begin
                if (pre != 0 && fi.inst_ready) void'(mq.pop_front());
                if (hit) begin
                    if (m_stale) begin
                        m_stale = 1'b0;
                        m_req   = 1'b0;
                    end else begin
                        mq.push_back('{pc: m_pc, d: inst_word(m_pc)});
                        m_pc = m_pc + 64'd4;
                        if (mq.size() < DEPTH) m_addr = m_pc;
                        else m_req = 1'b0;
                    end
                end else if (!m_req && pre < DEPTH) begin
                    m_req  = 1'b1;
                    m_addr = m_pc;
                end
            end
        end

        @(posedge CLK);
        @(negedge CLK);

        check_val("imem_req", 64'(fi.imem_req), 64'(m_req));
        check_val("imem_addr", fi.imem_addr, m_addr);
        check_val("count", 64'(count_w), 64'(mq.size()));
        check_val("inst_valid", 64'(fi.inst_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check_val("inst_pc", fi.inst_pc, mq[0].pc);
            check_val("inst_data", 64'(fi.inst_data), 64'(mq[0].d));
        end
    endtask

    task automatic do_reset(input logic [63:0] spc, input int n);
        startpc  = spc;
        resetl   = 1'b0;
        redirect = 1'b0;
        repeat (n) tick();
        resetl = 1'b1;
    endtask

    initial begin
        int n;
        n_vec = 0; n_bad = 0; acks = 0;
        mem_lat = 0; mem_cnt = 0; lat_rand = 0; force_ack = 1'b0;
        m_pc = '0; m_addr = '0; m_req = 1'b0; m_stale = 1'b0;
        resetl = 1'b0; startpc = '0; redirect = 1'b0; redirect_pc = '0;
        fi.inst_ready = 1'b0; fi.imem_ack = 1'b0; fi.imem_data = '0;
        @(negedge CLK);

        // Zero-wait streaming from reset release.
        mem_lat = 0; fi.inst_ready = 1'b1;
        do_reset(64'h1000, 2);
        check_val("rst_count", 64'(count_w), 64'd0);
        tick();
        check_val("s1_req", 64'(fi.imem_req), 64'd1);
        check_val("s1_addr", fi.imem_addr, 64'h1000);
        check_val("s1_novalid", 64'(fi.inst_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("s1_valid", 64'(fi.inst_valid), 64'd1);
            check_val("s1_pc", fi.inst_pc, 64'h1000 + 64'(4 * i));
        end

        // Fill with consumer stalled, then one pop buys exactly one request.
        fi.inst_ready = 1'b0;
        do_reset(64'h1000, 2);
        acks = 0;
        repeat (10) tick();
        check_val("s2_acks", 64'(acks), 64'd4);
        check_val("s2_count", 64'(count_w), 64'd4);
        check_val("s2_req", 64'(fi.imem_req), 64'd0);
        fi.inst_ready = 1'b1;
        tick();
        fi.inst_ready = 1'b0;
        acks = 0;
        repeat (6) tick();
        check_val("s2_refill", 64'(acks), 64'd1);
        check_val("s2_count2", 64'(count_w), 64'd4);

        // Redirect while a 3-cycle fetch of 0x1008 is pending.
        mem_lat = 2;
        do_reset(64'h1000, 2);
        n = 0;
        while (fi.imem_addr !== 64'h1008 && n < 40) begin tick(); n++; end
        check_val("s3_reach_1008", 64'(n < 40), 64'd1);
        redirect = 1'b1; redirect_pc = 64'h2000;
        tick();
        redirect = 1'b0; fi.inst_ready = 1'b1;
        n = 0;
        while (fi.inst_valid !== 1'b1 && n < 40) begin tick(); n++; end
        check_val("s3_reach_valid", 64'(n < 40), 64'd1);
        check_val("s3_first_pc", fi.inst_pc, 64'h2000);

        // Redirect on the same edge as an ack and a pop.
        mem_lat = 0; fi.inst_ready = 1'b0;
        do_reset(64'h1000, 2);
        n = 0;
        while (count_w !== 3'd2 && n < 40) begin tick(); n++; end
        check_val("s4_reach_cnt2", 64'(n < 40), 64'd1);
        redirect = 1'b1; redirect_pc = 64'h3000; fi.inst_ready = 1'b1;
        tick();
        redirect = 1'b0; fi.inst_ready = 1'b0;
        check_val("s4_count", 64'(count_w), 64'd0);
        check_val("s4_req_drop", 64'(fi.imem_req), 64'd0);
        tick();
        check_val("s4_req", 64'(fi.imem_req), 64'd1);
        check_val("s4_addr", fi.imem_addr, 64'h3000);

        // Address wrap at the top of the 64-bit space.
        mem_lat = 0; fi.inst_ready = 1'b1;
        do_reset(64'hFFFF_FFFF_FFFF_FFF8, 2);
        tick();
        tick(); check_val("s5_pc0", fi.inst_pc, 64'hFFFF_FFFF_FFFF_FFF8);
        tick(); check_val("s5_pc1", fi.inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(); check_val("s5_pc2", fi.inst_pc, 64'h0);

        // Reset in the middle of a request, then a late ack with no request.
        mem_lat = 3; fi.inst_ready = 1'b0;
        do_reset(64'h4000, 2);
        tick();
        check_val("s6_req", 64'(fi.imem_req), 64'd1);
        check_val("s6_addr", fi.imem_addr, 64'h4000);
        tick();
        resetl = 1'b0; startpc = 64'h5000;
        tick();
        check_val("s6_req_drop", 64'(fi.imem_req), 64'd0);
        check_val("s6_count_rst", 64'(count_w), 64'd0);
        resetl = 1'b1; force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        check_val("s6_no_push", 64'(count_w), 64'd0);
        check_val("s6_req2", 64'(fi.imem_req), 64'd1);
        check_val("s6_addr2", fi.imem_addr, 64'h5000);

        // Random traffic: latency, back-pressure, redirects, resets, spurious acks.
        lat_rand = 1;
        do_reset({$urandom, $urandom} & ~64'h3, 2);
        for (int i = 0; i < 2000; i++) begin
            fi.inst_ready = ($urandom_range(0, 9) < 7);
            force_ack     = ($urandom_range(0, 9) == 0);
            redirect      = ($urandom_range(0, 24) == 0);
            redirect_pc   = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0
                                                         : ({$urandom, $urandom} & ~64'h3);
            resetl        = !($urandom_range(0, 199) == 0);
            if (!resetl) startpc = {$urandom, $urandom} & ~64'h3;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
